// File: rtl/exc_seq_ctrl.sv
// exc_seq_ctrl: CP0 exception sequencer.
// Accepts syscall/break/eret from EX and reports the event to CP0 for one cycle.
// It then flushes and stalls the pipeline for FLUSH_CYCLES cycles and redirects
// the PC to the handler (syscall/break) or to EPC (eret).
// Optional feature: define EXC_SEQ_COUNT_EN to count accepted syscall+break events
// on exc_count_o. When the macro is undefined, exc_count_o is tied to 0.
module exc_seq_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syscall_i,
    input  logic             break_i,
    input  logic             eret_i,
    input  logic [31:0]      inst_addr_i,
    input  logic [31:0]      epc_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic [1:0]       cp0_type_o,
    output logic [31:0]      cp0_addr_o,
    output logic             pc_load_o,
    output logic [31:0]      pc_target_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] exc_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    localparam logic [1:0] KIND_SYSCALL = 2'b01;
    localparam logic [1:0] KIND_BREAK   = 2'b10;
    localparam logic [1:0] KIND_ERET    = 2'b11;
    localparam logic [3:0] FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  req_kind;
    logic [1:0]  kind_q;
    logic [31:0] addr_q;
    logic [31:0] epc_q;
    logic [31:0] tgt_q;
    logic [3:0]  cnt_q;

    // Priority-encode the incoming request: syscall > break > eret.
    always_comb begin
        req_kind = 2'b00;
        if (syscall_i)      req_kind = KIND_SYSCALL;
        else if (break_i)   req_kind = KIND_BREAK;
        else if (eret_i)    req_kind = KIND_ERET;
    end

    // Next-state logic and outputs, which are decoded from the state and the latched registers only.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        busy_o      = 1'b0;
        flush_o     = 1'b0;
        cp0_type_o  = 2'b00;
        pc_load_o   = 1'b0;
        cp0_addr_o  = addr_q;
        pc_target_o = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (req_kind != 2'b00) state_d = S_ENTER;
            end
            S_ENTER: begin
                stall_o    = 1'b1;
                busy_o     = 1'b1;
                flush_o    = 1'b1;
                cp0_type_o = kind_q;
                state_d    = (FLUSH_CYCLES == 1) ? S_REDIRECT : S_FLUSH;
            end
            S_FLUSH: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                flush_o = 1'b1;
                // The counter holds the number of FLUSH cycles still to run,
                // including this one.
                if (cnt_q <= 4'd1) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                stall_o   = 1'b1;
                busy_o    = 1'b1;
                pc_load_o = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latches, flush counter and PC target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= 2'b00;
            addr_q  <= '0;
            epc_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_kind != 2'b00) begin
                kind_q <= req_kind;
                addr_q <= inst_addr_i;
                epc_q  <= epc_i;
            end
            if (state_q == S_ENTER)
                cnt_q <= FLUSH_LOAD;
            else if (state_q == S_FLUSH)
                cnt_q <= cnt_q - 4'd1;
            if (state_d == S_REDIRECT && state_q != S_REDIRECT)
                tgt_q <= (kind_q == KIND_ERET) ? epc_q : HANDLER_ADDR;
        end
    end

`ifdef EXC_SEQ_COUNT_EN
    logic [CNT_W-1:0] exc_cnt_q;

    // Count each syscall/break as it passes through ENTER. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            exc_cnt_q <= '0;
        else if (state_q == S_ENTER && (kind_q == KIND_SYSCALL || kind_q == KIND_BREAK))
            exc_cnt_q <= exc_cnt_q + CNT_W'(1);
    end

    assign exc_count_o = exc_cnt_q;
`else
    assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// tb_exc_seq_ctrl: self-checking bench for exc_seq_ctrl.
// A cycle-offset reference model is checked against the DUT after every clock edge.
// The bench runs directed scenarios and then a randomized run.
module tb_exc_seq_ctrl;

    localparam int unsigned FC       = 3;
    localparam int unsigned TB_CNT_W = 4;
    localparam logic [31:0] HANDLER  = 32'h0000_0040;

    logic                clk = 1'b0;
    logic                rst;
    logic                syscall_i, break_i, eret_i;
    logic [31:0]         inst_addr_i, epc_i;
    logic                stall_o, flush_o, pc_load_o, busy_o;
    logic [1:0]          cp0_type_o;
    logic [31:0]         cp0_addr_o, pc_target_o;
    logic [TB_CNT_W-1:0] exc_count_o;

    exc_seq_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .FLUSH_CYCLES (FC),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall_i   (syscall_i),
        .break_i     (break_i),
        .eret_i      (eret_i),
        .inst_addr_i (inst_addr_i),
        .epc_i       (epc_i),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .cp0_type_o  (cp0_type_o),
        .cp0_addr_o  (cp0_addr_o),
        .pc_load_o   (pc_load_o),
        .pc_target_o (pc_target_o),
        .busy_o      (busy_o),
        .exc_count_o (exc_count_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // The model tracks the cycles elapsed since a request was accepted.
    bit          m_active;
    int          m_k;
    logic [1:0]  m_kind;
    logic [31:0] m_addr, m_epc, m_tgt;
    int unsigned m_cnt;

    // Pulse tallies of DUT outputs, used by the scenario-level checks.
    int n_load, n_type, n_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic sc, input logic br, input logic er,
                                input logic [31:0] addr, input logic [31:0] epc);
        bit was_idle;
        if (r) begin
            m_active = 0; m_k = 0; m_kind = 2'b00;
            m_addr = '0; m_epc = '0; m_tgt = '0; m_cnt = 0;
        end else begin
            was_idle = !m_active;
            if (m_active) begin
                m_k++;
                if (m_k == 2 && m_kind != 2'b11)
                    m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
                if (m_k == FC + 1)
                    m_tgt = (m_kind == 2'b11) ? m_epc : HANDLER;
                if (m_k > FC + 1)
                    m_active = 0;
            end
            if (was_idle && (sc || br || er)) begin
                m_active = 1;
                m_k      = 1;
                m_kind   = sc ? 2'b01 : (br ? 2'b10 : 2'b11);
                m_addr   = addr;
                m_epc    = epc;
            end
        end
    endtask

    task automatic step(input logic r, input logic sc, input logic br, input logic er,
                        input logic [31:0] addr, input logic [31:0] epc);
        logic [31:0] exp_cnt;
        rst = r; syscall_i = sc; break_i = br; eret_i = er;
        inst_addr_i = addr; epc_i = epc;
        @(posedge clk);
        model_update(r, sc, br, er, addr, epc);
        #1;
`ifdef EXC_SEQ_COUNT_EN
        exp_cnt = 32'(m_cnt);
`else
        exp_cnt = 32'd0;
`endif
        check("busy",   32'(busy_o),     32'(m_active));
        check("stall",  32'(stall_o),    32'(m_active));
        check("flush",  32'(flush_o),    32'(m_active && m_k <= FC));
        check("type",   32'(cp0_type_o), (m_active && m_k == 1) ? 32'(m_kind) : 32'd0);
        check("addr",   cp0_addr_o,      m_addr);
        check("load",   32'(pc_load_o),  32'(m_active && m_k == FC + 1));
        check("target", pc_target_o,     m_tgt);
        check("count",  32'(exc_count_o), exp_cnt);
        if (pc_load_o)          n_load++;
        if (cp0_type_o != 2'b0) n_type++;
        if (flush_o)            n_flush++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic clear_tally();
        n_load = 0; n_type = 0; n_flush = 0;
    endtask

    initial begin
        logic [31:0] cnt_before;
        m_active = 0; m_k = 0; m_kind = 0; m_addr = 0; m_epc = 0; m_tgt = 0; m_cnt = 0;
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 1, 32'hdead_beef, 32'h1234_5678);

        // A syscall at 0x100 is reported once, flushes for FC cycles and loads the handler address.
        clear_tally();
        step(0, 1, 0, 0, 32'h0000_0100, 32'h0);
        idle(FC + 3);
        check("sys_type_pulses", 32'(n_type), 32'd1);
        check("sys_flush_cycles", 32'(n_flush), 32'(FC));
        check("sys_loads", 32'(n_load), 32'd1);
        check("sys_target", pc_target_o, 32'h0000_0040);

        // An eret redirects to the latched EPC.
        clear_tally();
        step(0, 0, 0, 1, 32'h0000_0300, 32'h0000_0204);
        idle(FC + 3);
        check("eret_loads", 32'(n_load), 32'd1);
        check("eret_target", pc_target_o, 32'h0000_0204);

        // When all three requests arrive together, only the syscall is sequenced.
        clear_tally();
        step(0, 1, 1, 1, 32'h0000_0500, 32'h0000_0600);
        idle(FC + 3);
        check("all3_type_pulses", 32'(n_type), 32'd1);
        check("all3_loads", 32'(n_load), 32'd1);
        check("all3_target", pc_target_o, HANDLER);

        // A break that arrives during the flush of a syscall is ignored.
        clear_tally();
        step(0, 1, 0, 0, 32'h0000_0700, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 32'h0000_0800, 32'h0);
        idle(FC + 3);
        check("brk_in_flush_types", 32'(n_type), 32'd1);
        check("brk_in_flush_loads", 32'(n_load), 32'd1);

        // A reset during the flush aborts the sequence, and a later syscall runs normally.
        clear_tally();
        step(0, 1, 0, 0, 32'h0000_0900, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        idle(FC + 3);
        check("rst_abort_loads", 32'(n_load), 32'd0);
        clear_tally();
        step(0, 1, 0, 0, 32'h0000_0a00, 32'h0);
        idle(FC + 3);
        check("post_rst_loads", 32'(n_load), 32'd1);

        // 17 syscalls from reset wrap a 4-bit counter to 1. Two erets leave it unchanged.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 0, 0, 32'h1000 + 32'(i), 32'h0);
            idle(FC + 2);
        end
`ifdef EXC_SEQ_COUNT_EN
        check("count_wrap", 32'(exc_count_o), 32'd1);
`else
        check("count_wrap", 32'(exc_count_o), 32'd0);
`endif
        cnt_before = 32'(m_cnt);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 32'h2000, 32'h3000);
            idle(FC + 2);
        end
        check("count_eret_model", 32'(m_cnt), cnt_before);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
